// File: rtl/demodulation_pkg.sv
// Shared types and constants for the ten-segment demodulation decision block.
// Holds FSM state encoding, segment count and scan index width.
package demodulation_pkg;

  localparam int NUM_SEG = 10;
  localparam int IDX_W   = 4;

  typedef logic [IDX_W-1:0] seg_idx_t;

  localparam seg_idx_t LAST_IDX = seg_idx_t'(NUM_SEG - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/demodulation_segment_decision_if.sv
// Segment capture / decision result bundle; master is the upstream/consumer side,
// slave is the decision block. Result is held until ack, so no other backpressure.
interface demodulation_segment_decision_if #(
  parameter int SEG_W = 32
);
  import demodulation_pkg::*;

  logic             start;
  logic             in_valid;
  logic             ack;
  logic [SEG_W-1:0] segment_0;
  logic [SEG_W-1:0] segment_1;
  logic [SEG_W-1:0] segment_2;
  logic [SEG_W-1:0] segment_3;
  logic [SEG_W-1:0] segment_4;
  logic [SEG_W-1:0] segment_5;
  logic [SEG_W-1:0] segment_6;
  logic [SEG_W-1:0] segment_7;
  logic [SEG_W-1:0] segment_8;
  logic [SEG_W-1:0] segment_9;

  seg_idx_t         decision;
  logic [SEG_W-1:0] peak;
  logic [SEG_W-1:0] margin;
  logic             erasure;
  logic             valid;
  logic             busy;

  modport master (
    output start, in_valid, ack,
    output segment_0, segment_1, segment_2, segment_3, segment_4,
    output segment_5, segment_6, segment_7, segment_8, segment_9,
    input  decision, peak, margin, erasure, valid, busy
  );

  modport slave (
    input  start, in_valid, ack,
    input  segment_0, segment_1, segment_2, segment_3, segment_4,
    input  segment_5, segment_6, segment_7, segment_8, segment_9,
    output decision, peak, margin, erasure, valid, busy
  );

endinterface

// File: rtl/demodulation_segment_decision_max_tracker.sv
// Running best / second-best tracker; exposes next-state values so the caller can
// latch the final result on the same edge that processes the last segment.
module demodulation_max_tracker
  import demodulation_pkg::*;
#(
  parameter int SEG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_update,
  input  logic [SEG_W-1:0] i_value,
  input  seg_idx_t         i_idx,
  output logic [SEG_W-1:0] o_best,
  output logic [SEG_W-1:0] o_second,
  output seg_idx_t         o_best_idx
);

  logic [SEG_W-1:0] r_best;
  logic [SEG_W-1:0] r_second;
  seg_idx_t         r_best_idx;

  // Strict > keeps the lower index on ties; an equal value still lands in second.
  always_comb begin
    o_best     = r_best;
    o_second   = r_second;
    o_best_idx = r_best_idx;
    if (i_clear) begin
      o_best     = '0;
      o_second   = '0;
      o_best_idx = '0;
    end else if (i_update) begin
      if (i_value > r_best) begin
        o_best     = i_value;
        o_best_idx = i_idx;
        o_second   = r_best;
      end else if (i_value >= r_second) begin
        o_second = i_value;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_best     <= '0;
      r_second   <= '0;
      r_best_idx <= '0;
    end else begin
      r_best     <= o_best;
      r_second   <= o_second;
      r_best_idx <= o_best_idx;
    end
  end

endmodule

// File: rtl/demodulation_segment_decision.sv
// Snapshots ten segment metrics, scans one per cycle (valid 10 cycles after capture)
// and holds decision/peak/margin/erasure until ack; start low aborts and clears.
module demodulation_segment_decision
  import demodulation_pkg::*;
#(
  parameter int               SEG_W    = 32,
  parameter logic [SEG_W-1:0] MIN_PEAK = '0
) (
  input  logic clk,
  input  logic reset,
  demodulation_segment_decision_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  seg_idx_t         r_idx;
  logic [SEG_W-1:0] r_snap [NUM_SEG];
  logic [SEG_W-1:0] w_seg_in [NUM_SEG];

  seg_idx_t         r_decision;
  logic [SEG_W-1:0] r_peak;
  logic [SEG_W-1:0] r_margin;
  logic             r_erasure;
  logic             r_valid;
  logic             r_busy;

  logic             w_capture;
  logic             w_update;
  logic             w_last;
  logic             w_clear;
  logic [SEG_W-1:0] w_best;
  logic [SEG_W-1:0] w_second;
  seg_idx_t         w_best_idx;
  logic [SEG_W:0]   w_peak_diff;

  assign w_seg_in[0] = bus.segment_0;
  assign w_seg_in[1] = bus.segment_1;
  assign w_seg_in[2] = bus.segment_2;
  assign w_seg_in[3] = bus.segment_3;
  assign w_seg_in[4] = bus.segment_4;
  assign w_seg_in[5] = bus.segment_5;
  assign w_seg_in[6] = bus.segment_6;
  assign w_seg_in[7] = bus.segment_7;
  assign w_seg_in[8] = bus.segment_8;
  assign w_seg_in[9] = bus.segment_9;

  assign w_update = (r_state == ST_SCAN) && bus.start;
  assign w_last   = (r_state == ST_SCAN) && (r_idx == LAST_IDX);
  assign w_clear  = w_capture || !bus.start;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    if (!bus.start) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: if (bus.in_valid) begin
          w_state_nxt = ST_SCAN;
          w_capture   = 1'b1;
        end
        ST_SCAN: if (w_last) w_state_nxt = ST_DONE;
        ST_DONE: if (bus.ack) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  demodulation_max_tracker #(
    .SEG_W (SEG_W)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_update   (w_update),
    .i_value    (r_snap[r_idx]),
    .i_idx      (r_idx),
    .o_best     (w_best),
    .o_second   (w_second),
    .o_best_idx (w_best_idx)
  );

  // Borrow out of a one-bit-wider subtract is exactly peak < MIN_PEAK.
  assign w_peak_diff = {1'b0, w_best} - {1'b0, MIN_PEAK};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx      <= '0;
      r_snap     <= '{default: '0};
      r_decision <= '0;
      r_peak     <= '0;
      r_margin   <= '0;
      r_erasure  <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_busy  <= (w_state_nxt == ST_SCAN);
      r_valid <= (w_state_nxt == ST_DONE);
      if (w_capture) begin
        r_snap <= w_seg_in;
        r_idx  <= '0;
      end else if (!bus.start) begin
        r_idx <= '0;
      end else if (w_update && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end
      if (!bus.start) begin
        r_decision <= '0;
        r_peak     <= '0;
        r_margin   <= '0;
        r_erasure  <= 1'b0;
      end else if (w_update && w_last) begin
        r_decision <= w_best_idx;
        r_peak     <= w_best;
        r_margin   <= w_best - w_second;
        r_erasure  <= w_peak_diff[SEG_W];
      end
    end
  end

  assign bus.decision = r_decision;
  assign bus.peak     = r_peak;
  assign bus.margin   = r_margin;
  assign bus.erasure  = r_erasure;
  assign bus.valid    = r_valid;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_demodulation_segment_decision.sv
// Bench for demodulation_segment_decision: two instances (MIN_PEAK 0 and 50) share
// stimulus; a behavioural model is compared every cycle plus directed literal checks.
module tb_demodulation_segment_decision;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        ack;
  logic [31:0] seg [10];

  int checks   = 0;
  int failures = 0;

  demodulation_segment_decision_if #(.SEG_W(32)) if0 ();
  demodulation_segment_decision_if #(.SEG_W(32)) if1 ();

  assign if0.start = start;       assign if1.start = start;
  assign if0.in_valid = in_valid; assign if1.in_valid = in_valid;
  assign if0.ack = ack;           assign if1.ack = ack;
  assign if0.segment_0 = seg[0];  assign if1.segment_0 = seg[0];
  assign if0.segment_1 = seg[1];  assign if1.segment_1 = seg[1];
  assign if0.segment_2 = seg[2];  assign if1.segment_2 = seg[2];
  assign if0.segment_3 = seg[3];  assign if1.segment_3 = seg[3];
  assign if0.segment_4 = seg[4];  assign if1.segment_4 = seg[4];
  assign if0.segment_5 = seg[5];  assign if1.segment_5 = seg[5];
  assign if0.segment_6 = seg[6];  assign if1.segment_6 = seg[6];
  assign if0.segment_7 = seg[7];  assign if1.segment_7 = seg[7];
  assign if0.segment_8 = seg[8];  assign if1.segment_8 = seg[8];
  assign if0.segment_9 = seg[9];  assign if1.segment_9 = seg[9];

  demodulation_segment_decision #(.SEG_W(32), .MIN_PEAK(32'd0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave)
  );
  demodulation_segment_decision #(.SEG_W(32), .MIN_PEAK(32'd50)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 scanning, 2 result held.
  int          m_mode = 0;
  int          m_cnt  = 0;
  bit          m_chk  = 1'b1;
  logic [3:0]  m_dec, p_dec;
  logic [31:0] m_peak, m_margin, p_peak, p_margin;
  logic        m_era1;

  task automatic model_result();
    logic [31:0] mx, sc;
    int          bi;
    mx = seg[0];
    bi = 0;
    for (int i = 1; i < 10; i++) if (seg[i] > mx) begin mx = seg[i]; bi = i; end
    sc = 0;
    for (int i = 0; i < 10; i++) if (i != bi && seg[i] > sc) sc = seg[i];
    p_dec    = bi[3:0];
    p_peak   = mx;
    p_margin = mx - sc;
  endtask

  task automatic model_zero();
    m_mode = 0; m_chk = 1'b1;
    m_dec = '0; m_peak = '0; m_margin = '0; m_era1 = 1'b0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_zero();
    else if (!start) model_zero();
    else begin
      case (m_mode)
        0: if (in_valid) begin model_result(); m_mode = 1; m_cnt = 0; end
        1: begin
          m_cnt++;
          if (m_cnt == 10) begin
            m_mode = 2; m_chk = 1'b1;
            m_dec = p_dec; m_peak = p_peak; m_margin = p_margin;
            m_era1 = (p_peak < 32'd50);
          end
        end
        default: if (ack) begin m_mode = 0; m_chk = 1'b0; end
      endcase
    end
  end

  always @(negedge clk) begin
    check("busy0", if0.busy, m_mode == 1);
    check("valid0", if0.valid, m_mode == 2);
    check("busy1", if1.busy, m_mode == 1);
    check("valid1", if1.valid, m_mode == 2);
    if (m_chk) begin
      check("dec0", if0.decision, m_dec);
      check("peak0", if0.peak, m_peak);
      check("margin0", if0.margin, m_margin);
      check("erasure0", if0.erasure, 1'b0);
      check("dec1", if1.decision, m_dec);
      check("peak1", if1.peak, m_peak);
      check("margin1", if1.margin, m_margin);
      check("erasure1", if1.erasure, m_era1);
    end
  end

  task automatic capture(input logic [31:0] v [10]);
    seg = v;
    start = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts busy cycles until valid; ends on a negedge with valid high.
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (if0.valid) break;
      if (if0.busy) n++;
    end
    check({name, "_busy_cycles"}, n, 10);
    check({name, "_valid_seen"}, if0.valid, 1'b1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic expect_zero(input string name);
    check({name, "_valid"}, {if0.valid, if1.valid}, 2'b00);
    check({name, "_busy"}, {if0.busy, if1.busy}, 2'b00);
    check({name, "_dec"}, {if0.decision, if1.decision}, 8'h00);
    check({name, "_peak"}, {if0.peak, if1.peak}, 64'h0);
    check({name, "_margin"}, {if0.margin, if1.margin}, 64'h0);
    check({name, "_erasure"}, {if0.erasure, if1.erasure}, 2'b00);
  endtask

  logic [31:0] pat [10];

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; ack = 1'b0;
    for (int i = 0; i < 10; i++) seg[i] = '0;
    repeat (2) @(posedge clk); #1;
    expect_zero("reset");
    reset = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;

    // Tie on 9 at indices 1 and 3
    pat = '{5, 9, 3, 9, 1, 0, 2, 8, 7, 4};
    capture(pat);
    wait_valid("tie");
    check("tie_dec", if0.decision, 4'd1);
    check("tie_peak", if0.peak, 32'd9);
    check("tie_margin", if0.margin, 32'd0);
    check("tie_erasure", if0.erasure, 1'b0);
    do_ack();

    pat = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 100};
    capture(pat);
    wait_valid("last");
    check("last_dec", if1.decision, 4'd9);
    check("last_peak", if1.peak, 32'd100);
    check("last_margin", if1.margin, 32'd100);
    check("last_erasure", if1.erasure, 1'b0);
    do_ack();

    pat = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 10};
    capture(pat);
    wait_valid("flat");
    check("flat_dec", if1.decision, 4'd0);
    check("flat_margin", if1.margin, 32'd0);
    check("flat_erasure1", if1.erasure, 1'b1);
    check("flat_erasure0", if0.erasure, 1'b0);
    do_ack();

    // Abort four cycles into the scan
    pat = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    capture(pat);
    repeat (4) @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    expect_zero("abort");
    start = 1'b1;
    pat = '{5, 9, 3, 9, 1, 0, 2, 8, 7, 4};
    capture(pat);
    wait_valid("after_abort");
    check("after_abort_dec", if0.decision, 4'd1);
    check("after_abort_peak", if0.peak, 32'd9);

    // Hold without ack while inputs wander (result still from the previous capture)
    do_ack();
    pat = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 100};
    capture(pat);
    wait_valid("hold");
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      seg[k % 10] = $urandom;
      in_valid = k[0];
      check("hold_valid", if0.valid, 1'b1);
      check("hold_dec", if1.decision, 4'd9);
      check("hold_peak", if1.peak, 32'd100);
      check("hold_margin", if1.margin, 32'd100);
    end
    for (int i = 0; i < 10; i++) seg[i] = 32'd10;
    in_valid = 1'b1;
    do_ack();
    check("ack_idle_busy", if0.busy, 1'b0);
    check("ack_idle_valid", if0.valid, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid("recapture");
    check("recap_dec", if1.decision, 4'd0);
    check("recap_erasure", if1.erasure, 1'b1);
    do_ack();

    // Asynchronous reset between edges mid-scan
    pat = '{7, 7, 7, 70, 7, 7, 7, 7, 7, 7};
    capture(pat);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    expect_zero("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    pat = '{0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0};
    capture(pat);
    wait_valid("post_reset");
    check("post_reset_dec", if0.decision, 4'd3);
    check("post_reset_peak", if0.peak, 32'hFFFF_FFFF);
    check("post_reset_margin", if0.margin, 32'hFFFF_FFFF);
    check("post_reset_erasure1", if1.erasure, 1'b0);
    do_ack();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demodulation_segment_decision.md
DEMODULATION_SEGMENT_DECISION -- requirements
Module: demodulation_segment_decision

Interface
REQ-001 SHALL have parameter SEG_W, default 32, width of each segment word.
REQ-002 SHALL have parameter MIN_PEAK, default 0, unsigned erasure threshold on the winning segment.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level enable; low aborts and clears the block.
REQ-006 SHALL have port in_valid  input  1  upstream demodulator segment outputs are valid.
REQ-007 SHALL have ports segment_0 .. segment_9  input  SEG_W each  unsigned segment metrics from the upstream demodulator.
REQ-008 SHALL have port ack  input  1  consumer has taken the result.
REQ-009 SHALL have port decision  output  4  index 0..9 of the largest segment.
REQ-010 SHALL have port peak  output  SEG_W  value of the winning segment.
REQ-011 SHALL have port margin  output  SEG_W  peak minus second-largest value.
REQ-012 SHALL have port erasure  output  1  peak < MIN_PEAK.
REQ-013 SHALL have port valid  output  1  decision, peak, margin and erasure are valid.
REQ-014 SHALL have port busy  output  1  capture or scan in progress.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-016 IDLE: start=1 and in_valid=1 at an edge SHALL snapshot all ten segments into local registers, clear the scan index to 0, and enter SCAN.
REQ-017 SCAN SHALL compare exactly one snapshot segment per cycle in order 0..9, unsigned, against a running best and second-best.
REQ-018 Ties SHALL keep the lower index as best; an equal value SHALL become second-best, giving margin 0.
REQ-019 After index 9 is processed, the FSM SHALL enter DONE, so valid rises 10 cycles after the capture edge.
REQ-020 Segment inputs and in_valid SHALL be ignored during SCAN and DONE.
REQ-021 DONE: valid=1 and outputs SHALL hold stable until an edge with ack=1, then return to IDLE.
REQ-022 Ack together with start=1 and in_valid=1 in DONE SHALL return to IDLE only; no same-cycle recapture.
REQ-023 Ack outside DONE SHALL be ignored.
REQ-024 start=0 at any edge SHALL force IDLE, clear valid and busy, and zero all outputs, taking priority over ack.
REQ-025 busy SHALL be 1 exactly in SCAN; valid SHALL be 1 exactly in DONE; both registered.
REQ-026 margin SHALL be computed as an unsigned subtraction at SEG_W bits, which never underflows because best >= second.
REQ-027 Erasure SHALL be registered on entry to DONE; with MIN_PEAK=0 it SHALL always be 0.

Reset
REQ-028 While reset=1, the block SHALL set state=IDLE, scan index=0, snapshot, best and second to 0, and decision, peak, margin, erasure, valid and busy to 0.
REQ-029 Reset asserted mid-SCAN or in DONE SHALL discard the result; the first capture after release SHALL behave as from power-up.

Structure
REQ-030 Shared package demodulation_pkg SHALL hold the FSM state typedef, the NUM_SEG=10 constant and the index width of 4.
REQ-031 SHALL contain one sub-module, demodulation_max_tracker, holding the best/second registers and the compare logic, with a clear and an update input.

Verification
REQ-032 The bench SHALL apply segments 5,9,3,9,1,0,2,8,7,4 with start=1 and in_valid=1 for one edge, and SHALL check: busy=1 for 10 cycles, then valid=1 with decision=1, peak=9, margin=0, erasure=0.
REQ-033 The bench SHALL apply all segments 0 except segment_9=100 with MIN_PEAK=50, and SHALL check: decision=9, peak=100, margin=100, erasure=0.
REQ-034 The bench SHALL apply all segments 10 with MIN_PEAK=50, and SHALL check: decision=0, margin=0, erasure=1.
REQ-035 The bench SHALL drop start to 0 four cycles into SCAN, and SHALL check: next edge valid=0, busy=0, outputs 0, then a fresh capture produces a correct result.
REQ-036 The bench SHALL hold valid with ack=0 for 20 cycles while changing segment inputs, and SHALL check: outputs stable; then ack=1 leads to IDLE, and a recapture with in_valid=1 on the following edge succeeds.
REQ-037 The bench SHALL assert reset asynchronously mid-SCAN between clock edges, and SHALL check: all outputs 0 immediately; segment_3=0xFFFFFFFF after release gives decision=3, peak=0xFFFFFFFF.
